mem_port_arbiter: RTL

Shares the CPU's single synchronous-read memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage). Each cycle it grants at most one access, with data priority and a fetch-starvation guard. It drives byte enables and lane-replicated write data for stores, and returns load data that is lane-aligned and sign- or zero-extended per funct3. It sits between the pipeline stages and the unified instruction/data RAM, and its stall outputs feed the hazard unit.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/load_align.sv | 28 ++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port arbiter: funct3 codes, response
// encoding and the access legality check used at grant time.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // What the memory port will hand back on the cycle after a grant.
    typedef enum logic [2:0] {
        RESP_NONE  = 3'd0,
        RESP_FETCH = 3'd1,
        RESP_LOAD  = 3'd2,
        RESP_STORE = 3'd3,
        RESP_ERR   = 3'd4
    } resp_e;

    // True when a data access is misaligned or carries an illegal funct3.
    function automatic logic access_err(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad_f3;
        logic misal;
        if (is_store) begin
            bad_f3 = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        end else begin
            bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        // f3[1:0]==01 covers h/hu, ==10 covers w.
        misal = ((f3[1:0] == 2'b01) && off[0]) ||
                ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 | misal;
    endfunction

endpackage

// File: rtl/load_align.sv
// Shifts the addressed lane of a memory word down to bit 0 and extends it
// according to the load funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // Lane select followed by sign/zero extension.
    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        data_o  = 32'd0;
        case (f3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'd0, shifted[7:0]};
            F3_HU:   data_o = {16'd0, shifted[15:0]};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined synchronous-read memory port between instruction fetch
// and data access. Data has priority; a starvation counter forces a waiting
// fetch through after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_valid_o,
    output logic [31:0]       if_instr_o,
    input  logic              dm_rd_i,
    input  logic              dm_wr_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    input  logic [2:0]        dm_funct3_i,
    output logic              dm_gnt_o,
    output logic              dm_done_o,
    output logic [31:0]       dm_rdata_o,
    output logic              dm_err_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              if_stall_o,
    output logic              dm_stall_o,
    output logic [CNT_W-1:0]  starve_cnt_o,
    output logic [2:0]        resp_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    resp_e            resp_q, resp_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;

    logic        dm_req, is_store, dm_bad, if_win, dm_win;
    logic [1:0]  dm_off;
    logic [3:0]  st_we;
    logic [31:0] st_wdata, ld_data;
    resp_e       resp_live;

    // Fetch address byte-offset bits carry no meaning for a word fetch.
    logic unused_if_off;
    assign unused_if_off = ^if_addr_i[1:0];

    // Arbitration: data first unless the fetch has waited STARVE_LIMIT grants.
    always_comb begin
        dm_req   = dm_rd_i | dm_wr_i;
        is_store = dm_wr_i;
        dm_off   = dm_addr_i[1:0];
        dm_bad   = access_err(is_store, dm_funct3_i, dm_off);
        if_win   = 1'b0;
        dm_win   = 1'b0;
        if (!rst_i) begin
            if (dm_req && if_req_i) begin
                if (starve_q == LIMIT) if_win = 1'b1;
                else                   dm_win = 1'b1;
            end else if (dm_req) begin
                dm_win = 1'b1;
            end else if (if_req_i) begin
                if_win = 1'b1;
            end
        end
    end

    // Store lane steering: replicate the data and enable the addressed bytes.
    always_comb begin
        st_we    = 4'b0000;
        st_wdata = 32'd0;
        case (dm_funct3_i)
            F3_B: begin
                st_we    = 4'b0001 << dm_off;
                st_wdata = {4{dm_wdata_i[7:0]}};
            end
            F3_H: begin
                st_we    = 4'b0011 << dm_off;
                st_wdata = {2{dm_wdata_i[15:0]}};
            end
            F3_W: begin
                st_we    = 4'b1111;
                st_wdata = dm_wdata_i;
            end
            default: ;
        endcase
    end

    // Memory port drive; an erroring data grant performs no access.
    always_comb begin
        if_gnt_o    = if_win;
        dm_gnt_o    = dm_win;
        if_stall_o  = !rst_i && if_req_i && !if_win;
        dm_stall_o  = !rst_i && dm_req && !dm_win;
        mem_en_o    = if_win || (dm_win && !dm_bad);
        mem_we_o    = (dm_win && is_store && !dm_bad) ? st_we : 4'b0000;
        mem_wdata_o = (dm_win && is_store && !dm_bad) ? st_wdata : 32'd0;
        mem_addr_o  = '0;
        if (if_win)      mem_addr_o = if_addr_i[ADDR_W-1:2];
        else if (dm_win) mem_addr_o = dm_addr_i[ADDR_W-1:2];
    end

    // Next response type, load formatting capture and starvation count.
    always_comb begin
        resp_d   = RESP_NONE;
        off_d    = off_q;
        f3_d     = f3_q;
        starve_d = starve_q;
        if (if_win) begin
            resp_d = RESP_FETCH;
        end else if (dm_win) begin
            off_d = dm_off;
            f3_d  = dm_funct3_i;
            if (dm_bad)        resp_d = RESP_ERR;
            else if (is_store) resp_d = RESP_STORE;
            else               resp_d = RESP_LOAD;
        end
        if (!if_req_i || if_win) begin
            starve_d = '0;
        end else if (dm_win && starve_q != LIMIT) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Response tracker and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q   <= RESP_NONE;
            starve_q <= '0;
            off_q    <= 2'b00;
            f3_q     <= 3'b000;
        end else begin
            resp_q   <= resp_d;
            starve_q <= starve_d;
            off_q    <= off_d;
            f3_q     <= f3_d;
        end
    end

    load_align u_load_align (
        .word_i (mem_rdata_i),
        .off_i  (off_q),
        .f3_i   (f3_q),
        .data_o (ld_data)
    );

    // Response outputs; reset masks anything still in flight.
    always_comb begin
        resp_live    = rst_i ? RESP_NONE : resp_q;
        if_valid_o   = (resp_live == RESP_FETCH);
        if_instr_o   = (resp_live == RESP_FETCH) ? mem_rdata_i : 32'd0;
        dm_done_o    = (resp_live == RESP_LOAD) || (resp_live == RESP_STORE) ||
                       (resp_live == RESP_ERR);
        dm_err_o     = (resp_live == RESP_ERR);
        dm_rdata_o   = (resp_live == RESP_LOAD) ? ld_data : 32'd0;
        starve_cnt_o = rst_i ? '0 : starve_q;
        resp_o       = resp_live;
    end

endmodule
